// File: rtl/branch_ctrl.sv
// Branch controller: IDLE/RUN/DONE sequencer, target LUT and optional return-address stack.
// The return-address stack (CALL/RET) is built only when BRANCH_CTRL_RAS_EN is defined.
module branch_ctrl #(
    parameter int L         = 10,
    parameter int LUT_AW    = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [2:0]        BrOp,
    input  logic [LUT_AW-1:0] LutIdx,
    input  logic              ALU_flag,
    input  logic [L-1:0]      ProgCtr,
    input  logic              LutWrEn,
    input  logic [LUT_AW-1:0] LutWrIdx,
    input  logic [L-1:0]      LutWrData,
    output logic              BranchAbs,
    output logic [L-1:0]      Target,
    output logic              Done,
    output logic              RasOvf,
    output logic              RasUnf,
    output logic [1:0]        DbgState
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_JMP  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    state_t         state, state_nxt;
    logic [L-1:0]   lut [2**LUT_AW];
    logic           lut_we;
    logic           ras_clr;

`ifdef BRANCH_CTRL_RAS_EN
    localparam int CW = $clog2(RAS_DEPTH + 1);
    logic [L-1:0]  ras [RAS_DEPTH];
    logic [CW-1:0] ras_cnt;
    logic          ras_full, ras_push, ras_pop, ovf_set, unf_set;
    logic          ovf_q, unf_q;
    assign ras_full = (ras_cnt == CW'(RAS_DEPTH));
`endif

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Writes are accepted only while no program is executing; reads never see a same-cycle write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 2**LUT_AW; i++) lut[i] <= '0;
        end else if (lut_we) begin
            lut[LutWrIdx] <= LutWrData;
        end
    end

    // Branch outputs are combinational so the PC loads Target on the same edge; Start is level-sampled.
    always_comb begin
        state_nxt = state;
        BranchAbs = 1'b0;
        Target    = '0;
        lut_we    = 1'b0;
        ras_clr   = 1'b0;
`ifdef BRANCH_CTRL_RAS_EN
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                lut_we = LutWrEn;
                if (Start) begin
                    state_nxt = RUN;
                    ras_clr   = 1'b1;
                end
            end
            RUN: begin
                case (BrOp)
                    OP_BEQ: if (ALU_flag) begin
                        BranchAbs = 1'b1;
                        Target    = lut[LutIdx];
                    end
                    OP_BNE: if (!ALU_flag) begin
                        BranchAbs = 1'b1;
                        Target    = lut[LutIdx];
                    end
                    OP_JMP: begin
                        BranchAbs = 1'b1;
                        Target    = lut[LutIdx];
                    end
                    OP_CALL: begin
                        BranchAbs = 1'b1;
                        Target    = lut[LutIdx];
`ifdef BRANCH_CTRL_RAS_EN
                        ras_push  = !ras_full;
                        ovf_set   = ras_full;
`endif
                    end
`ifdef BRANCH_CTRL_RAS_EN
                    OP_RET: begin
                        if (ras_cnt != '0) begin
                            BranchAbs = 1'b1;
                            Target    = ras[0];
                            ras_pop   = 1'b1;
                        end else begin
                            unf_set   = 1'b1;
                        end
                    end
`endif
                    OP_HALT: state_nxt = DONE;
                    default: ;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BRANCH_CTRL_RAS_EN
    always_ff @(posedge Clk) begin
        if (Reset || ras_clr) begin
            ras_cnt <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (ras_push)     ras_cnt <= ras_cnt + CW'(1);
            else if (ras_pop) ras_cnt <= ras_cnt - CW'(1);
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
        end
    end

    // Shift-register stack: ras[0] is always the top entry.
    always_ff @(posedge Clk) begin
        if (ras_push) begin
            ras[0] <= ProgCtr + L'(1);
            for (int i = 1; i < RAS_DEPTH; i++) ras[i] <= ras[i-1];
        end else if (ras_pop) begin
            for (int i = 0; i < RAS_DEPTH - 1; i++) ras[i] <= ras[i+1];
        end
    end

    assign RasOvf = ovf_q;
    assign RasUnf = unf_q;
`else
    logic unused_ras;
    assign unused_ras = ^{ProgCtr, ras_clr};
    assign RasOvf     = 1'b0;
    assign RasUnf     = 1'b0;
`endif

    assign Done     = (state == DONE);
    assign DbgState = state;

endmodule
